// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, the
// starvation limit default, the read-owner encoding and a saturating
// counter helper used by the optional statistics block.
package dmem_arbiter_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int ADDR_W_DEF       = 5;
  localparam int STARVE_LIMIT_DEF = 4;

  // Which port a read response in flight belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating event counters for the data-memory arbiter: grants per port
// and cycles where both ports requested. Only built when the top-level
// is compiled with DMEM_ARB_STATS_EN defined.
module dmem_arb_stats
  import dmem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        grant_a_i,
  input  logic        grant_b_i,
  input  logic        conflict_i,
  output logic [15:0] a_grants_o,
  output logic [15:0] b_grants_o,
  output logic [15:0] conflicts_o
);

  logic [15:0] a_grants_q, a_grants_d;
  logic [15:0] b_grants_q, b_grants_d;
  logic [15:0] conflicts_q, conflicts_d;

  // Next counts: bump on the matching event, never wrap past all-ones
  always_comb begin
    a_grants_d  = a_grants_q;
    b_grants_d  = b_grants_q;
    conflicts_d = conflicts_q;
    if (grant_a_i) begin
      a_grants_d = sat_inc16(a_grants_q);
    end else begin
      a_grants_d = a_grants_q;
    end
    if (grant_b_i) begin
      b_grants_d = sat_inc16(b_grants_q);
    end else begin
      b_grants_d = b_grants_q;
    end
    if (conflict_i) begin
      conflicts_d = sat_inc16(conflicts_q);
    end else begin
      conflicts_d = conflicts_q;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_grants_q  <= 16'd0;
      b_grants_q  <= 16'd0;
      conflicts_q <= 16'd0;
    end else begin
      a_grants_q  <= a_grants_d;
      b_grants_q  <= b_grants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign a_grants_o  = a_grants_q;
  assign b_grants_o  = b_grants_q;
  assign conflicts_o = conflicts_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port data memory between the load/store unit
// (port A, fixed priority) and a debug/loader port (port B). Port B is
// forced a grant after waiting STARVE_LIMIT consecutive cycles. Read data
// comes back one cycle after the grant, steered by a registered owner tag.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined;
// otherwise the stat ports read as zero.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_a_grants,
  output logic [15:0]       stat_b_grants,
  output logic [15:0]       stat_conflicts
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  owner_e     owner_q, owner_d;
  logic       force_b;
  logic       grant_a;
  logic       grant_b;

  // Grant decision: A has priority unless B has waited long enough
  always_comb begin
    force_b = b_valid && (starve_q == LIMIT_C);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end else if (a_valid && !force_b) begin
      grant_a = 1'b1;
    end else if (b_valid) begin
      grant_b = 1'b1;
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  // Memory drive muxed from the granted port, all-zero when idle
  always_comb begin
    a_ready   = grant_a;
    b_ready   = grant_b;
    mem_en    = grant_a | grant_b;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (grant_a) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (grant_b) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Starvation count and read owner for the next cycle
  always_comb begin
    starve_d = starve_q;
    owner_d  = OWN_NONE;
    if (!b_valid || grant_b) begin
      starve_d = 4'd0;
    end else if (starve_q == LIMIT_C) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 4'd1;
    end
    if (grant_a && !a_we) begin
      owner_d = OWN_A;
    end else if (grant_b && !b_we) begin
      owner_d = OWN_B;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Response steering; a response still in flight is dropped while in reset
  always_comb begin
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    a_rdata  = {DATA_W{1'b0}};
    b_rdata  = {DATA_W{1'b0}};
    if (rst) begin
      a_rvalid = 1'b0;
      b_rvalid = 1'b0;
    end else begin
      case (owner_q)
        OWN_A: begin
          a_rvalid = 1'b1;
          a_rdata  = mem_rdata;
        end
        OWN_B: begin
          b_rvalid = 1'b1;
          b_rdata  = mem_rdata;
        end
        default: begin
          a_rvalid = 1'b0;
          b_rvalid = 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .grant_a_i   (grant_a),
    .grant_b_i   (grant_b),
    .conflict_i  (a_valid && b_valid),
    .a_grants_o  (stat_a_grants),
    .b_grants_o  (stat_b_grants),
    .conflicts_o (stat_conflicts)
  );
`else
  assign stat_a_grants  = 16'd0;
  assign stat_b_grants  = 16'd0;
  assign stat_conflicts = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a random
// traffic run compared against a behavioural model of the arbitration
// rules and a shadow copy of the memory contents.
module tb_dmem_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;

  logic          clk;
  logic          rst;
  logic          a_valid, a_ready, a_we, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   stat_a_grants, stat_b_grants, stat_conflicts;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem_arr [32];
  logic [DW-1:0] ref_mem [32];

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants),
    .stat_conflicts(stat_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_we = 1'b0; a_addr = 5'd0; a_wdata = 32'd0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = 5'd0; b_wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    a_valid = 1'b1;
    b_valid = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    n_tests++;
    if ({a_ready, b_ready, mem_en, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready_mem got=%b exp=0000", {a_ready, b_ready, mem_en, mem_we});
    end
    n_tests++;
    if ({a_rvalid, b_rvalid, mem_addr} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_rvalid_addr got=%b exp=0", {a_rvalid, b_rvalid, mem_addr});
    end
    n_tests++;
    if ({stat_a_grants, stat_b_grants, stat_conflicts} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_stats got=%h exp=0", {stat_a_grants, stat_b_grants, stat_conflicts});
    end
    idle();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 32'd77;
    @(negedge clk);
    n_tests++;
    if ({a_ready, b_ready, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 5'd3, 32'd77}) begin
      n_fail++;
      $display("FAIL a_only_write got=%h exp=%h", {a_ready, b_ready, mem_we, mem_addr, mem_wdata},
               {1'b1, 1'b0, 1'b1, 5'd3, 32'd77});
    end
    cyc();
    ref_mem[3] = 32'd77;
    a_we = 1'b0; a_wdata = 32'd0;
    @(negedge clk);
    n_tests++;
    if ({a_ready, b_ready, mem_we, a_rvalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL a_only_read_issue got=%b exp=1000", {a_ready, b_ready, mem_we, a_rvalid});
    end
    cyc();
    idle();
    @(negedge clk);
    n_tests++;
    if ({a_rvalid, a_rdata, b_ready, b_rvalid} !== {1'b1, 32'd77, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL a_only_resp got=%h exp=%h", {a_rvalid, a_rdata, b_ready, b_rvalid},
               {1'b1, 32'd77, 1'b0, 1'b0});
    end
    cyc();
    @(negedge clk);
    n_tests++;
    if (a_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL a_only_single_rvalid got=%b exp=0", a_rvalid);
    end
    cyc();
  endtask

  task automatic test_preload_dump();
    int rdy_cnt = 0;
    int a_rdy   = 0;
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      b_valid = 1'b1; b_we = 1'b1; b_addr = 5'(i); b_wdata = v;
      ref_mem[i] = v;
      @(negedge clk);
      if (b_ready === 1'b1) rdy_cnt++;
      if (a_ready !== 1'b0) a_rdy++;
      cyc();
    end
    n_tests++;
    if (rdy_cnt != 32 || a_rdy != 0) begin
      n_fail++;
      $display("FAIL preload_ready got=%0d/%0d exp=32/0", rdy_cnt, a_rdy);
    end
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) begin
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'(i); b_wdata = 32'd0;
      end else begin
        idle();
      end
      @(negedge clk);
      if (i > 0) begin
        n_tests++;
        if ({b_rvalid, b_rdata} !== {1'b1, ref_mem[i-1]}) begin
          n_fail++;
          $display("FAIL dump[%0d] got=%h exp=%h", i - 1, {b_rvalid, b_rdata}, {1'b1, ref_mem[i-1]});
        end
      end
      cyc();
    end
  endtask

  task automatic test_interleaved();
    b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd1; b_wdata = 32'd10;
    cyc();
    b_addr = 5'd2; b_wdata = 32'd20;
    cyc();
    ref_mem[1] = 32'd10;
    ref_mem[2] = 32'd20;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd1;
    b_we = 1'b0; b_addr = 5'd2; b_wdata = 32'd0;
    @(negedge clk);
    n_tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL inter_a_first got=%b exp=10", {a_ready, b_ready});
    end
    cyc();
    a_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({b_ready, a_rvalid, a_rdata, b_rvalid} !== {1'b1, 1'b1, 32'd10, 1'b0}) begin
      n_fail++;
      $display("FAIL inter_a_resp got=%h exp=%h", {b_ready, a_rvalid, a_rdata, b_rvalid},
               {1'b1, 1'b1, 32'd10, 1'b0});
    end
    cyc();
    idle();
    @(negedge clk);
    n_tests++;
    if ({b_rvalid, b_rdata, a_rvalid, a_rdata} !== {1'b1, 32'd20, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL inter_b_resp got=%h exp=%h", {b_rvalid, b_rdata, a_rvalid, a_rdata},
               {1'b1, 32'd20, 1'b0, 32'd0});
    end
    cyc();
  endtask

  task automatic test_contention();
    logic pa = 1'b0, pb = 1'b0, exp_b;
    logic [DW-1:0] pda = 32'd0, pdb = 32'd0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 5'($urandom_range(0, 31));
    b_valid = 1'b1; b_we = 1'b0; b_addr = 5'($urandom_range(0, 31));
    for (int k = 0; k < 15; k++) begin
      exp_b = ((k % 5) == 4);
      @(negedge clk);
      n_tests++;
      if ({a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata} !== {!exp_b, exp_b, pa, pb, pda, pdb}) begin
        n_fail++;
        $display("FAIL contention[%0d] got=%h exp=%h", k,
                 {a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata}, {!exp_b, exp_b, pa, pb, pda, pdb});
      end
      pa  = !exp_b;
      pb  = exp_b;
      pda = exp_b ? 32'd0 : ref_mem[a_addr];
      pdb = exp_b ? ref_mem[b_addr] : 32'd0;
      cyc();
      if (exp_b) b_addr = 5'($urandom_range(0, 31));
      else       a_addr = 5'($urandom_range(0, 31));
    end
    idle();
    @(negedge clk);
    n_tests++;
    if ({a_rvalid, b_rvalid, b_rdata} !== {1'b0, 1'b1, pdb}) begin
      n_fail++;
      $display("FAIL contention_last_resp got=%h exp=%h", {a_rvalid, b_rvalid, b_rdata}, {1'b0, 1'b1, pdb});
    end
    cyc();
  endtask

  task automatic test_reset_mid_read();
    b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd5;
    @(negedge clk);
    n_tests++;
    if (b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_b_grant got=%b exp=1", b_ready);
    end
    cyc();
    rst = 1'b1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd0;
    @(negedge clk);
    n_tests++;
    if ({a_ready, b_ready, mem_en, mem_we, a_rvalid, b_rvalid, mem_addr} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got=%b exp=0",
               {a_ready, b_ready, mem_en, mem_we, a_rvalid, b_rvalid, mem_addr});
    end
    cyc();
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_tests++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_after got=%b exp=00", {a_rvalid, b_rvalid});
    end
    cyc();
    // Build up B's wait, then check reset clears it
    a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd7;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd8;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (b_ready !== (k == 4)) begin
        n_fail++;
        $display("FAIL midrst_starve[%0d] got=%b exp=%b", k, b_ready, (k == 4));
      end
      cyc();
    end
    idle();
    cyc();
  endtask

  task automatic test_stats();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    idle();
    cyc();
    @(negedge clk);
    n_tests++;
`ifdef DMEM_ARB_STATS_EN
    if ({stat_a_grants, stat_b_grants, stat_conflicts} !== {16'd8, 16'd2, 16'd10}) begin
      n_fail++;
      $display("FAIL stats got=%0d/%0d/%0d exp=8/2/10", stat_a_grants, stat_b_grants, stat_conflicts);
    end
`else
    if ({stat_a_grants, stat_b_grants, stat_conflicts} !== 48'd0) begin
      n_fail++;
      $display("FAIL stats got=%0d/%0d/%0d exp=0/0/0", stat_a_grants, stat_b_grants, stat_conflicts);
    end
`endif
    cyc();
  endtask

  task automatic test_random();
    int bwait = 0;
    int own   = 0;
    logic [DW-1:0] od = 32'd0;
    logic ga, gb, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic [106:0] exp_v, act_v;
    idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      // B wins when A is absent or B has already waited the limit
      gb    = b_valid && (!a_valid || bwait == LIM);
      ga    = a_valid && !gb;
      ewe   = ga ? a_we : (gb ? b_we : 1'b0);
      eaddr = ga ? a_addr : (gb ? b_addr : 5'd0);
      ewd   = ga ? a_wdata : (gb ? b_wdata : 32'd0);
      exp_v = {ga, gb, ga | gb, ewe, eaddr, ewd, own == 1, own == 2,
               (own == 1) ? od : 32'd0, (own == 2) ? od : 32'd0};
      act_v = {a_ready, b_ready, mem_en, mem_we, mem_addr, mem_wdata, a_rvalid, b_rvalid, a_rdata, b_rdata};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h exp=%h", c, act_v, exp_v);
      end
      own = 0;
      if (ga) begin
        if (a_we) ref_mem[a_addr] = a_wdata;
        else begin own = 1; od = ref_mem[a_addr]; end
      end else if (gb) begin
        if (b_we) ref_mem[b_addr] = b_wdata;
        else begin own = 2; od = ref_mem[b_addr]; end
      end
      if (b_valid && !gb) bwait = (bwait < LIM) ? bwait + 1 : LIM;
      else                bwait = 0;
      cyc();
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = 5'($urandom_range(0, 31));
        a_wdata = $urandom;
      end
      if (!b_valid || gb) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = 5'($urandom_range(0, 31));
        b_wdata = $urandom;
      end
    end
    idle();
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_a_only();
    test_preload_dump();
    test_interleaved();
    test_contention();
    test_reset_mid_read();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
